// File: rtl/dot_accumulator_if.sv
// Product-in / element-out stream bundle for the dot-product accumulator.
// master drives products and consumes results; slave is the accumulator.
interface dot_accumulator_if #(
  parameter int unsigned ACC_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           out_data;
  logic [ACC_WIDTH-1:0] out_raw;
  logic                 out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_raw, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_raw, out_sat
  );
endinterface

// File: rtl/dot_accumulator.sv
// Sums N_TERMS signed 4-bit products into one element; emits the raw sum and a
// copy saturated back to the 4-bit product format.
module dot_accumulator #(
  parameter int unsigned N_TERMS   = 8,
  parameter int unsigned ACC_WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  dot_accumulator_if.slave bus
);

  localparam int unsigned CntW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic signed [ACC_WIDTH-1:0] SatMax = ACC_WIDTH'(7);
  localparam logic signed [ACC_WIDTH-1:0] SatMin = ACC_WIDTH'(-8);

  typedef enum logic [0:0] {StAcc, StOut} state_e;

  state_e state_q, state_d;

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] raw_q;
  logic        [CntW-1:0]      cnt_q;
  logic        [3:0]           data_q;
  logic                        sat_q;

  logic signed [ACC_WIDTH-1:0] in_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic        [3:0]           sat_data;
  logic                        sat_flag;
  logic                        accept;
  logic                        last;

  assign in_ext = {{(ACC_WIDTH-4){bus.in_data[3]}}, bus.in_data};
  assign sum    = acc_q + in_ext;
  assign accept = bus.in_valid && (state_q == StAcc);
  assign last   = accept && (cnt_q == CntW'(N_TERMS - 1));

  always_comb begin
    sat_data = sum[3:0];
    sat_flag = 1'b0;
    if (sum > SatMax) begin
      sat_data = 4'h7;
      sat_flag = 1'b1;
    end else if (sum < SatMin) begin
      sat_data = 4'h8;
      sat_flag = 1'b1;
    end
  end

  // Output registers only load on the closing beat, so they hold through OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      raw_q  <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else if (accept) begin
      if (last) begin
        acc_q  <= '0;
        cnt_q  <= '0;
        raw_q  <= sum;
        data_q <= sat_data;
        sat_q  <= sat_flag;
      end else begin
        acc_q <= sum;
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAcc;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAcc:   if (last) state_d = StOut;
      StOut:   if (bus.out_ready) state_d = StAcc;
      default: state_d = StAcc;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == StAcc);
    bus.out_valid = (state_q == StOut);
    bus.out_data  = data_q;
    bus.out_raw   = raw_q;
    bus.out_sat   = sat_q;
  end

endmodule

// File: tb/tb_dot_accumulator.sv
// Table-driven and hand-sequenced checks of dot_accumulator with a result
// scoreboard popped on every output handshake.
module tb_dot_accumulator;

  localparam int unsigned NT = 8;
  localparam int unsigned AW = 8;

  typedef struct packed {
    logic [AW-1:0] raw;
    logic [3:0]    data;
    logic          sat;
  } exp_t;

  typedef struct packed {
    logic [31:0]   beats;  // beat i in nibble i
    logic [AW-1:0] raw;
    logic [3:0]    data;
    logic          sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  dot_accumulator_if #(.ACC_WIDTH(AW)) bus ();

  dot_accumulator #(
    .N_TERMS  (NT),
    .ACC_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int sum);
    exp_t        e;
    logic [31:0] s;
    s     = sum;
    e.raw = s[AW-1:0];
    if (sum > 7) begin
      e.data = 4'h7;
      e.sat  = 1'b1;
    end else if (sum < -8) begin
      e.data = 4'h8;
      e.sat  = 1'b1;
    end else begin
      e.data = s[3:0];
      e.sat  = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got raw 0x%0h, want no output", bus.out_raw);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_raw", 32'(bus.out_raw), 32'(e.raw));
        check("out_data", 32'(bus.out_data), 32'(e.data));
        check("out_sat", 32'(bus.out_sat), 32'(e.sat));
      end
    end
  end

  task automatic send_beat(input logic [3:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready) begin
      n++;
      if (n >= 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL beat_accept: got in_ready 0 for 50 cycles, want 1");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Ends at 1 time unit after a rising edge.
  task automatic send_elem(input logic [31:0] beats, input exp_t e, input bit gaps,
                           input bit push, input bit lat_chk);
    logic [31:0] t;
    for (int i = 0; i < NT; i++) begin
      if (gaps) begin
        for (int k = 0; k < 3 && $urandom_range(1) == 1; k++) begin
          @(posedge clk);
          #1;
        end
      end
      t = beats >> (4 * i);
      if (i == NT - 1 && push) sb.push_back(e);
      send_beat(t[3:0]);
    end
    if (lat_chk) begin
      @(negedge clk);
      check("latency_out_valid", 32'(bus.out_valid), 32'd1);
      check("out_in_ready_low", 32'(bus.in_ready), 32'd0);
      if (bus.out_ready) begin
        @(negedge clk);
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_random_elem();
    logic [31:0] r;
    logic [31:0] t;
    int          sum;
    r   = $urandom;
    sum = 0;
    for (int i = 0; i < NT; i++) begin
      t   = r >> (4 * i);
      sum = sum + int'($signed(t[3:0]));
    end
    send_elem(r, model(sum), 1'b1, 1'b1, 1'b0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{beats: 32'h11111111, raw: 8'h08, data: 4'h7, sat: 1'b1};
    vecs[1] = '{beats: 32'hE3E3E3E3, raw: 8'h04, data: 4'h4, sat: 1'b0};
    vecs[2] = '{beats: 32'h88888888, raw: 8'hC0, data: 4'h8, sat: 1'b1};
    vecs[3] = '{beats: 32'h77777777, raw: 8'h38, data: 4'h7, sat: 1'b1};
    vecs[4] = '{beats: 32'hD00EF321, raw: 8'h00, data: 4'h0, sat: 1'b0};
    vecs[5] = '{beats: 32'hFFFFFFFF, raw: 8'hF8, data: 4'h8, sat: 1'b0};
    vecs[6] = '{beats: 32'h00000007, raw: 8'h07, data: 4'h7, sat: 1'b0};
    vecs[7] = '{beats: 32'h000000F8, raw: 8'hF7, data: 4'h8, sat: 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_raw", 32'(bus.out_raw), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_sat", 32'(bus.out_sat), 32'd0);
    @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      exp_t e;
      e = '{raw: vecs[v].raw, data: vecs[v].data, sat: vecs[v].sat};
      send_elem(vecs[v].beats, e, 1'b0, 1'b1, 1'b1);
    end

    // Backpressure: result held, upstream keeps offering beats that must be ignored.
    bus.out_ready = 1'b0;
    send_elem(32'h22222222, '{raw: 8'h10, data: 4'h7, sat: 1'b1}, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 4'(k + 1);
      @(negedge clk);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_out_raw", 32'(bus.out_raw), 32'h10);
      check("hold_out_data", 32'(bus.out_data), 32'h7);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_elem(32'h21212121, '{raw: 8'h0C, data: 4'h7, sat: 1'b1}, 1'b0, 1'b1, 1'b1);

    for (int k = 0; k < 3; k++) send_random_elem();

    // Reset mid-element discards the partial sum of 5.
    for (int k = 0; k < 5; k++) send_beat(4'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    send_elem(32'h11111111, '{raw: 8'h08, data: 4'h7, sat: 1'b1}, 1'b0, 1'b1, 1'b1);

    // Reset while a result is held drops it.
    bus.out_ready = 1'b0;
    send_elem(32'h33333333, '{raw: 8'h18, data: 4'h7, sat: 1'b1}, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("outrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("outrst_out_raw", 32'(bus.out_raw), 32'd0);
    check("outrst_out_sat", 32'(bus.out_sat), 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_random_elem();

    repeat (4) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
